// File: rtl/fighter_pkg.sv
// Shared fighter-core types and arena defaults used by every player instance.
package fighter_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    LAND   = 2'd3
  } move_st_t;

  localparam int ARENA_X_MIN    = 0;
  localparam int ARENA_X_MAX    = 600;
  localparam int ARENA_GROUND_Y = 400;

endpackage

// File: rtl/jump_arc.sv
// Vertical integrator for one player: launch velocity, gravity with fall-speed
// saturation, ceiling clamp at y=0 and touchdown detection at the ground line.
module jump_arc
  import fighter_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int VEL_W    = 8,
  parameter int GROUND_Y = ARENA_GROUND_Y,
  parameter int JUMP_VEL = 20,
  parameter int GRAVITY  = 2,
  parameter int MAX_FALL = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             launch_i,
  input  logic             airborne_i,
  output logic [POS_W-1:0] pos_y_o,
  output logic             touchdown_o,
  output logic             apex_o
);

  // Two guard bits keep pos+vel free of overflow for any pos/vel combination.
  localparam int YW = POS_W + 2;
  localparam logic signed [YW-1:0]    GROUND_S = YW'(GROUND_Y);
  localparam logic signed [VEL_W:0]   GRAV_S   = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   MAXF_S   = (VEL_W + 1)'(MAX_FALL);
  localparam logic signed [VEL_W-1:0] MAXF_V   = VEL_W'(MAX_FALL);
  localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(-JUMP_VEL);

  logic [POS_W-1:0]        pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic signed [YW-1:0]    sum;
  logic signed [VEL_W:0]   vsum;
  logic signed [VEL_W-1:0] vel_nxt;
  logic                    hit_ground;

  // Integrate position with the old velocity, then apply saturated gravity.
  always_comb begin
    sum        = $signed({2'b00, pos_y_q}) + $signed({{(YW - VEL_W){vel_q[VEL_W-1]}}, vel_q});
    vsum       = $signed({vel_q[VEL_W-1], vel_q}) + GRAV_S;
    vel_nxt    = (vsum > MAXF_S) ? MAXF_V : vsum[VEL_W-1:0];
    hit_ground = (sum >= GROUND_S);
    pos_y_d    = pos_y_q;
    vel_d      = vel_q;
    if (tick_i) begin
      if (launch_i) begin
        vel_d = JUMP_V;
      end else if (airborne_i) begin
        if (hit_ground) begin
          pos_y_d = POS_W'(GROUND_Y);
          vel_d   = '0;
        end else if (sum[YW-1]) begin
          pos_y_d = '0;
          vel_d   = vel_nxt;
        end else begin
          pos_y_d = sum[POS_W-1:0];
          vel_d   = vel_nxt;
        end
      end
    end
  end

  // Vertical state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_y_q <= POS_W'(GROUND_Y);
      vel_q   <= '0;
    end else begin
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
    end
  end

  assign pos_y_o     = pos_y_q;
  assign touchdown_o = airborne_i & hit_ground;
  assign apex_o      = ~vel_nxt[VEL_W-1];

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion engine: walk, jump arc, landing recovery, facing and
// push-box separation, all advanced on frame_tick.
// Optional build macro PLAYER_AIR_CONTROL_EN enables half-speed steering in the air.
module player_motion_ctrl
  import fighter_pkg::*;
#(
  parameter int POS_W       = 10,
  parameter int VEL_W       = 8,
  parameter int X_MIN       = ARENA_X_MIN,
  parameter int X_MAX       = ARENA_X_MAX,
  parameter int GROUND_Y    = ARENA_GROUND_Y,
  parameter int START_X     = 100,
  parameter int START_RIGHT = 1,
  parameter int WALK_SPD    = 4,
  parameter int JUMP_VEL    = 20,
  parameter int GRAVITY     = 2,
  parameter int MAX_FALL    = 24,
  parameter int MIN_SEP     = 32,
  parameter int LAND_TICKS  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             jump,
  input  logic [POS_W-1:0] opponent_x,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             facing_right,
  output logic             jump_active,
  output logic             move_active,
  output logic             x_lock,
  output logic             landed
);

  localparam int XW    = POS_W + 2;
  localparam int CNT_W = (LAND_TICKS > 0) ? $clog2(LAND_TICKS + 1) : 1;
  localparam logic signed [XW-1:0] XMIN_S = XW'(X_MIN);
  localparam logic signed [XW-1:0] XMAX_S = XW'(X_MAX);
  localparam logic signed [XW-1:0] SEP_S  = XW'(MIN_SEP);

  move_st_t         state_q, state_d;
  logic [CNT_W-1:0] land_cnt_q, land_cnt_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic             facing_q, facing_d;
  logic             move_q, move_d;
  logic             landed_q, landed_d;
  logic             jump_prev_q, jump_pend_q, jump_pend_d;
  logic             jump_req, launch, airborne, touchdown, apex;

  logic                 dir_l, dir_r, x_en, toward, reject;
  logic signed [XW-1:0] px, opx, step, cand, dx, adx;

  assign jump_req    = jump_pend_q | (jump & ~jump_prev_q);
  assign jump_pend_d = frame_tick ? 1'b0 : jump_req;
  assign airborne    = (state_q == RISE) || (state_q == FALL);

  jump_arc #(
    .POS_W   (POS_W),
    .VEL_W   (VEL_W),
    .GROUND_Y(GROUND_Y),
    .JUMP_VEL(JUMP_VEL),
    .GRAVITY (GRAVITY),
    .MAX_FALL(MAX_FALL)
  ) u_arc (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (frame_tick),
    .launch_i   (launch),
    .airborne_i (airborne),
    .pos_y_o    (pos_y),
    .touchdown_o(touchdown),
    .apex_o     (apex)
  );

  // Motion state machine: jump launch, apex, touchdown and landing recovery.
  always_comb begin
    state_d    = state_q;
    land_cnt_d = land_cnt_q;
    landed_d   = 1'b0;
    launch     = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        GROUND: begin
          if (jump_req) begin
            launch  = 1'b1;
            state_d = RISE;
          end
        end
        RISE, FALL: begin
          if (touchdown) begin
            landed_d   = 1'b1;
            land_cnt_d = CNT_W'(LAND_TICKS);
            state_d    = (LAND_TICKS == 0) ? GROUND : LAND;
          end else if (state_q == RISE && apex) begin
            state_d = FALL;
          end
        end
        LAND: begin
          if (land_cnt_q <= CNT_W'(1)) state_d = GROUND;
          else                         land_cnt_d = land_cnt_q - CNT_W'(1);
        end
        default: state_d = GROUND;
      endcase
    end
  end

  // Horizontal step with arena clamp, separation rejection and facing update.
  always_comb begin
    dir_l = move_left & ~move_right;
    dir_r = move_right & ~move_left;
`ifdef PLAYER_AIR_CONTROL_EN
    x_en  = (state_q != LAND);
`else
    x_en  = (state_q == GROUND);
`endif
    px     = $signed({2'b00, pos_x_q});
    opx    = $signed({2'b00, opponent_x});
    step   = (state_q == GROUND) ? XW'(WALK_SPD) : XW'(WALK_SPD / 2);
    cand   = dir_r ? (px + step) : (px - step);
    if (cand < XMIN_S)      cand = XMIN_S;
    else if (cand > XMAX_S) cand = XMAX_S;
    toward = (dir_r && (opx > px)) || (dir_l && (opx < px));
    dx     = cand - opx;
    adx    = dx[XW-1] ? -dx : dx;
    reject = toward && (adx < SEP_S);
    pos_x_d  = pos_x_q;
    move_d   = move_q;
    facing_d = facing_q;
    if (frame_tick) begin
      if (x_en && (dir_l || dir_r) && !reject) pos_x_d = cand[POS_W-1:0];
      move_d = (pos_x_d != pos_x_q);
      if (state_q == GROUND) begin
        if (opponent_x > pos_x_q)      facing_d = 1'b1;
        else if (opponent_x < pos_x_q) facing_d = 1'b0;
      end
    end
  end

  // Control and horizontal state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GROUND;
      land_cnt_q  <= '0;
      pos_x_q     <= POS_W'(START_X);
      facing_q    <= (START_RIGHT != 0);
      move_q      <= 1'b0;
      landed_q    <= 1'b0;
      jump_prev_q <= 1'b0;
      jump_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      land_cnt_q  <= land_cnt_d;
      pos_x_q     <= pos_x_d;
      facing_q    <= facing_d;
      move_q      <= move_d;
      landed_q    <= landed_d;
      jump_prev_q <= jump;
      jump_pend_q <= jump_pend_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign facing_right = facing_q;
  assign jump_active  = airborne;
  assign move_active  = move_q;
  assign landed       = landed_q;
`ifdef PLAYER_AIR_CONTROL_EN
  assign x_lock = (state_q == LAND);
`else
  assign x_lock = (state_q != GROUND);
`endif

endmodule
